branch_sched: RTL and testbench

BRANCH_SCHED -- requirements
Module: branch_sched

---
 rtl/branch_sched.sv | 185 ++++++++++++++++++
 tb/tb_branch_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_sched.sv
// Branch scheduler: allocates branch units in order, tracks condition
// evaluation per unit and resolves branches strictly in allocation order.
// A mispredicted resolution triggers a fixed-length pipeline flush.
module branch_sched #(
    parameter int NUM_BR       = 2,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      issue_br_i,
    output logic                      issue_stall_o,
    output logic [NUM_BR-1:0]         br_write_o,
    input  logic [NUM_BR-1:0]         cond_eval_i,
    input  logic [NUM_BR-1:0]         corr_pred_i,
    output logic                      resolve_valid_o,
    output logic                      resolve_corr_o,
    output logic [$clog2(NUM_BR)-1:0] resolve_unit_o,
    output logic                      flush_o
);

    localparam int IW  = $clog2(NUM_BR);
    localparam int CW  = $clog2(NUM_BR + 1);
    localparam int FCW = 4;

    localparam logic [CW-1:0]  COUNT_FULL = CW'(NUM_BR);
    localparam logic [IW-1:0]  PTR_LAST   = IW'(NUM_BR - 1);
    localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_BR-1:0]  busy_q, busy_d;
    logic [NUM_BR-1:0]  pend_q, pend_d;
    logic [NUM_BR-1:0]  corr_q, corr_d;
    logic [IW-1:0]      head_q, head_d;
    logic [IW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [FCW-1:0]     fcnt_q, fcnt_d;

    // Order FIFO contents; validity is tracked by head/tail/count only
    logic [IW-1:0]      order_fifo [NUM_BR];

    logic               in_run;
    logic [IW-1:0]      head_unit;
    logic [IW-1:0]      alloc_idx;
    logic               alloc_fire;
    logic               res_fire;
    logic               mispredict;
    logic [NUM_BR-1:0]  eval_ok;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + IW'(1);
    endfunction

    assign in_run    = (state_q == ST_RUN);
    assign head_unit = order_fifo[head_q];
    assign eval_ok   = cond_eval_i & busy_q;

    // Lowest-index free unit; scanning downward lets the lowest index win
    always_comb begin
        alloc_idx = '0;
        for (int i = NUM_BR - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alloc_idx = IW'(i);
            end
        end
    end

    // Issue side: stall when full or flushing, otherwise strobe the chosen unit
    always_comb begin
        issue_stall_o = !in_run || (count_q == COUNT_FULL);
        alloc_fire    = issue_br_i && !issue_stall_o;
    end

    generate
        for (genvar gi = 0; gi < NUM_BR; gi++) begin : g_wr
            assign br_write_o[gi] = alloc_fire && (alloc_idx == IW'(gi));
        end
    endgenerate

    // Resolution outputs: only the FIFO head may resolve, and only in RUN
    always_comb begin
        res_fire        = in_run && (count_q != '0) && pend_q[head_unit];
        resolve_valid_o = res_fire;
        resolve_unit_o  = res_fire ? head_unit : '0;
        resolve_corr_o  = res_fire && corr_q[head_unit];
        mispredict      = res_fire && !corr_q[head_unit];
        flush_o         = (state_q == ST_FLUSH);
    end

    // Next-state logic for the FSM, per-unit bits, pointers and flush counter
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        corr_d  = corr_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fcnt_d  = fcnt_q;

        case (state_q)
            ST_RUN: begin
                // Condition results only count for units holding a branch
                pend_d = pend_q | eval_ok;
                corr_d = (corr_q & ~eval_ok) | (corr_pred_i & eval_ok);

                if (alloc_fire) begin
                    busy_d[alloc_idx] = 1'b1;
                    tail_d            = ptr_inc(tail_q);
                end

                if (res_fire) begin
                    busy_d[head_unit] = 1'b0;
                    pend_d[head_unit] = 1'b0;
                    head_d            = ptr_inc(head_q);
                end

                case ({alloc_fire, res_fire})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase

                // A mispredict discards every in-flight branch, including
                // anything allocated or evaluated on the same edge
                if (mispredict) begin
                    state_d = ST_FLUSH;
                    busy_d  = '0;
                    pend_d  = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    fcnt_d  = FLUSH_LOAD;
                end
            end

            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FCW'(1);
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= ST_RUN;
            busy_q  <= '0;
            pend_q  <= '0;
            corr_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            corr_q  <= corr_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Order FIFO storage: push the allocated unit index at the tail
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            order_fifo[tail_q] <= alloc_idx;
        end
    end

endmodule

// File: tb/tb_branch_sched.sv
// Randomized and directed bench for branch_sched, checked every cycle
// against a queue-based reference model of the scheduling rules.
module tb_branch_sched;

    localparam int N = 2;
    localparam int F = 3;

    logic         clk;
    logic         reset_n;
    logic         issue_br;
    logic         issue_stall;
    logic [N-1:0] br_write;
    logic [N-1:0] cond_eval;
    logic [N-1:0] corr_pred;
    logic         resolve_valid;
    logic         resolve_corr;
    logic [0:0]   resolve_unit;
    logic         flush;

    int n_pass = 0;
    int n_chk  = 0;

    // Reference model state
    int q_m[$];
    bit busy_m [N];
    bit pend_m [N];
    bit corr_m [N];
    int flush_left;

    branch_sched #(.NUM_BR(N), .FLUSH_CYCLES(F)) dut (
        .clk_i           (clk),
        .reset_i         (reset_n),
        .issue_br_i      (issue_br),
        .issue_stall_o   (issue_stall),
        .br_write_o      (br_write),
        .cond_eval_i     (cond_eval),
        .corr_pred_i     (corr_pred),
        .resolve_valid_o (resolve_valid),
        .resolve_corr_o  (resolve_corr),
        .resolve_unit_o  (resolve_unit),
        .flush_o         (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        for (int i = 0; i < N; i++) begin
            busy_m[i] = 0;
            pend_m[i] = 0;
            corr_m[i] = 0;
        end
        flush_left = 0;
    endtask

    // One clock cycle: drive, check against model, clock, advance model.
    // Entered and left at 1 time unit after a rising edge.
    task automatic step(input bit iss, input logic [N-1:0] ce, input logic [N-1:0] cp);
        bit in_fl, e_stall, e_alloc, e_rv, e_rc;
        int a_u, e_ru, e_wr, h;
        issue_br  = iss;
        cond_eval = ce;
        corr_pred = cp;
        #2;
        in_fl   = (flush_left > 0);
        e_stall = in_fl || (q_m.size() == N);
        e_alloc = iss && !e_stall;
        a_u = 0;
        for (int i = N - 1; i >= 0; i--) if (!busy_m[i]) a_u = i;
        e_wr = e_alloc ? (1 << a_u) : 0;
        e_rv = !in_fl && (q_m.size() > 0) && pend_m[q_m[0]];
        e_ru = e_rv ? q_m[0] : 0;
        e_rc = e_rv && corr_m[q_m[0]];

        chk("stall", int'(issue_stall), int'(e_stall));
        chk("br_write", int'(br_write), e_wr);
        chk("res_valid", int'(resolve_valid), int'(e_rv));
        chk("flush", int'(flush), int'(in_fl));
        if (e_rv) begin
            chk("res_unit", int'(resolve_unit), e_ru);
            chk("res_corr", int'(resolve_corr), int'(e_rc));
        end
        $display("t=%0t iss=%0b ce=%b cp=%b stall=%0b wr=%b rv=%0b ru=%0d rc=%0b fl=%0b",
                 $time, iss, ce, cp, issue_stall, br_write, resolve_valid,
                 resolve_unit, resolve_corr, flush);

        @(posedge clk);
        if (in_fl) begin
            flush_left--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (ce[k] && busy_m[k]) begin
                    pend_m[k] = 1;
                    corr_m[k] = cp[k];
                end
            end
            if (e_rv) begin
                h = q_m.pop_front();
                busy_m[h] = 0;
                pend_m[h] = 0;
            end
            if (e_alloc) begin
                busy_m[a_u] = 1;
                q_m.push_back(a_u);
            end
            if (e_rv && !e_rc) begin
                q_m.delete();
                for (int i = 0; i < N; i++) begin
                    busy_m[i] = 0;
                    pend_m[i] = 0;
                end
                flush_left = F;
            end
        end
        #1;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge
    task automatic do_reset();
        issue_br  = 1'b0;
        cond_eval = '0;
        corr_pred = '0;
        reset_n   = 1'b0;
        #1;
        chk("rst_flush", int'(flush), 0);
        chk("rst_stall", int'(issue_stall), 0);
        chk("rst_wr", int'(br_write), 0);
        chk("rst_rv", int'(resolve_valid), 0);
        chk("rst_rc", int'(resolve_corr), 0);
        chk("rst_ru", int'(resolve_unit), 0);
        $display("t=%0t reset pulse", $time);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n   = 1'b1;
        issue_br  = 1'b0;
        cond_eval = '0;
        corr_pred = '0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Evaluation pulse on idle unit is ignored
        step(0, 2'b01, 2'b01);
        step(0, 2'b00, 2'b00);

        // Fill both units, then stall
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);

        // Out-of-order evaluation still resolves in allocation order
        step(0, 2'b10, 2'b10);
        step(0, 2'b00, 2'b00);
        step(0, 2'b01, 2'b01);
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);

        // Mispredict on head while unit 1 busy -> flush, unit 1 dropped
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);
        step(0, 2'b01, 2'b00);
        step(1, 2'b10, 2'b10);
        step(1, 2'b10, 2'b10);
        step(1, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);

        // Full FIFO with head resolving while issue requested
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);
        step(1, 2'b01, 2'b01);
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);
        step(1, 2'b00, 2'b00);

        // Reset in the middle of a flush
        step(0, 2'b11, 2'b00);
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);
        do_reset();
        step(1, 2'b00, 2'b00);
        step(0, 2'b00, 2'b00);

        // Randomized traffic with rare mispredicts and occasional resets
        for (int it = 0; it < 3000; it++) begin
            logic [N-1:0] ce, cp;
            ce = N'($urandom_range(0, 3));
            for (int k = 0; k < N; k++) cp[k] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(bit'($urandom_range(0, 1)), ce, cp);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
